// File: rtl/ofdm_tx_pkg.sv
// rtl/ofdm_tx_pkg.sv - shared constants, scrambler taps and state enum for the OFDM tx feeder
package ofdm_tx_pkg;

  localparam int BITS_PER_SYM   = 6;
  localparam int N_DSC          = 48;
  localparam int BYTES_PER_OFDM = N_DSC * BITS_PER_SYM / 8;

  localparam logic [6:0] SCR_SEED   = 7'b1111111;
  localparam int         SCR_TAP_HI = 6;
  localparam int         SCR_TAP_LO = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } tx_state_e;

endpackage

// File: rtl/tx_scrambler8.sv
// rtl/tx_scrambler8.sv - combinational 8-step x^7+x^4+1 scrambler, bit 0 processed first
module tx_scrambler8
  import ofdm_tx_pkg::*;
(
  input  logic [6:0] state_i,
  input  logic [7:0] byte_i,
  output logic [6:0] state_o,
  output logic [7:0] byte_o
);

  logic [6:0] s;
  logic       fb;

  always_comb begin
    s      = state_i;
    fb     = 1'b0;
    byte_o = '0;
    for (int i = 0; i < 8; i++) begin
      fb        = s[SCR_TAP_HI] ^ s[SCR_TAP_LO];
      byte_o[i] = byte_i[i] ^ fb;
      s         = {s[5:0], fb};
    end
    state_o = s;
  end

endmodule

// File: rtl/tx_scramble_pack.sv
// rtl/tx_scramble_pack.sv - scramble payload bytes, pack into 6-bit symbols, pad to whole OFDM symbols
// Optional feature: TX_SCRAMBLE_EN (defined = scrambler active, undefined = bits pass through).
module tx_scramble_pack #(
  parameter logic [6:0] SEED           = ofdm_tx_pkg::SCR_SEED,
  parameter int         BYTES_PER_OFDM = ofdm_tx_pkg::BYTES_PER_OFDM
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic [7:0] DAT_I,
  input  logic       CYC_I,
  input  logic       WE_I,
  input  logic       STB_I,
  output logic       ACK_O,
  output logic [5:0] DAT_O,
  output logic       CYC_O,
  output logic       STB_O,
  output logic       WE_O,
  input  logic       ACK_I
);
  import ofdm_tx_pkg::*;

  localparam logic [5:0] BCNT_LAST = 6'(BYTES_PER_OFDM - 1);
  localparam logic [3:0] SYM_W     = 4'(BITS_PER_SYM);

  tx_state_e   state_q, state_d;
  logic [12:0] bitbuf_q, bitbuf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  bcnt_q, bcnt_d;
  logic        cyc_q, cyc_d;

  logic       accept, inject, take, pop;
  logic [7:0] raw_byte, tx_byte;

  // Accept and pop are mutually exclusive by construction: cnt<=5 versus cnt>=6.
  assign ACK_O  = !RST_I && CYC_I && STB_I && WE_I && (cnt_q <= 4'd5) && (state_q != ST_FLUSH);
  assign accept = ACK_O;
  assign inject = (state_q == ST_FLUSH) && (bcnt_q != 6'd0) && (cnt_q <= 4'd5);
  assign take   = accept || inject;
  assign STB_O  = (cnt_q >= SYM_W);
  assign pop    = STB_O && ACK_I;
  assign DAT_O  = bitbuf_q[5:0];
  assign CYC_O  = cyc_q;
  assign WE_O   = cyc_q;

  assign raw_byte = inject ? 8'h00 : DAT_I;

`ifdef TX_SCRAMBLE_EN
  logic [6:0] scr_q, scr_d, scr_in, scr_out;

  // A frame's first byte always starts from SEED regardless of leftover state.
  assign scr_in = (state_q == ST_IDLE) ? SEED : scr_q;
  assign scr_d  = take ? scr_out : scr_q;

  tx_scrambler8 u_scr (
    .state_i (scr_in),
    .byte_i  (raw_byte),
    .state_o (scr_out),
    .byte_o  (tx_byte)
  );

  always_ff @(posedge CLK_I) begin
    if (RST_I) scr_q <= SEED;
    else       scr_q <= scr_d;
  end
`else
  logic seed_unused;
  assign seed_unused = ^SEED;
  assign tx_byte     = raw_byte;
`endif

  always_comb begin
    bitbuf_d = bitbuf_q;
    cnt_d    = cnt_q;
    bcnt_d   = bcnt_q;
    state_d  = state_q;
    cyc_d    = cyc_q;

    if (pop) begin
      bitbuf_d = bitbuf_q >> BITS_PER_SYM;
      cnt_d    = cnt_q - SYM_W;
    end else if (take) begin
      bitbuf_d = bitbuf_q | (13'(tx_byte) << cnt_q);
      cnt_d    = cnt_q + 4'd8;
    end

    if (take) begin
      if (state_q == ST_IDLE)       bcnt_d = 6'd1;
      else if (bcnt_q == BCNT_LAST) bcnt_d = 6'd0;
      else                          bcnt_d = bcnt_q + 6'd1;
    end

    // Leave as soon as the last symbol has gone so CYC_O drops the cycle after it.
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RUN;
          cyc_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (!CYC_I) begin
          if ((bcnt_d == 6'd0) && (cnt_d == 4'd0)) begin
            state_d = ST_IDLE;
            cyc_d   = 1'b0;
          end else begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if ((bcnt_d == 6'd0) && (cnt_d == 4'd0)) begin
          state_d = ST_IDLE;
          cyc_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q  <= ST_IDLE;
      bitbuf_q <= '0;
      cnt_q    <= '0;
      bcnt_q   <= '0;
      cyc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitbuf_q <= bitbuf_d;
      cnt_q    <= cnt_d;
      bcnt_q   <= bcnt_d;
      cyc_q    <= cyc_d;
    end
  end

endmodule

// File: tb/tb_tx_scramble_pack.sv
// tb/tb_tx_scramble_pack.sv - scoreboard bench for tx_scramble_pack
module tb_tx_scramble_pack;

  localparam logic [6:0] SEED_TB = 7'h7F;
  localparam int         BPO     = 36;

  logic       clk = 1'b0;
  logic       rst, cyc_i, stb_i, we_i, ack_i;
  logic [7:0] dat_i;
  logic       ack_o, stb_o, cyc_o, we_o;
  logic [5:0] dat_o;

  int         n_vec = 0;
  int         n_err = 0;
  int         n_xfer = 0;
  int         frame_base = 0;
  logic [5:0] first_sym;
  logic [5:0] exp_sym;
  bit         rand_ack = 1'b0;

  logic [6:0]  m_s;
  logic [31:0] m_bits;
  int          m_nbits, m_bytes;
  logic [5:0]  exp_q[$];

`ifdef TX_SCRAMBLE_EN
  localparam logic [5:0] FIRST_123 = 6'h31;
  localparam logic [5:0] FIRST_00  = 6'h30;
`else
  localparam logic [5:0] FIRST_123 = 6'h01;
  localparam logic [5:0] FIRST_00  = 6'h00;
`endif

  tx_scramble_pack #(.SEED(SEED_TB)) dut (
    .CLK_I (clk),
    .RST_I (rst),
    .DAT_I (dat_i),
    .CYC_I (cyc_i),
    .WE_I  (we_i),
    .STB_I (stb_i),
    .ACK_O (ack_o),
    .DAT_O (dat_o),
    .CYC_O (cyc_o),
    .STB_O (stb_o),
    .WE_O  (we_o),
    .ACK_I (ack_i)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && stb_o && ack_i) begin
        if (n_xfer == frame_base) first_sym = dat_o;
        n_xfer++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sym_unexpected: got %h, required nothing queued", dat_o);
        end else begin
          exp_sym = exp_q.pop_front();
          if (dat_o !== exp_sym) begin
            n_err++;
            $display("FAIL sym_order: got %h, required %h", dat_o, exp_sym);
          end
        end
      end
    end
  end

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] o;
    if (m_bytes == 0) m_s = SEED_TB;
    o = b;
`ifdef TX_SCRAMBLE_EN
    for (int i = 0; i < 8; i++) begin
      logic fb;
      fb   = m_s[6] ^ m_s[3];
      o[i] = b[i] ^ fb;
      m_s  = {m_s[5:0], fb};
    end
`endif
    m_bits  = m_bits | (32'(o) << m_nbits);
    m_nbits = m_nbits + 8;
    while (m_nbits >= 6) begin
      exp_q.push_back(m_bits[5:0]);
      m_bits  = m_bits >> 6;
      m_nbits = m_nbits - 6;
    end
    m_bytes++;
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
    if (rand_ack) ack_i = 1'($urandom_range(0, 1));
  endtask

  task automatic begin_frame();
    frame_base = n_xfer;
    m_bytes    = 0;
    m_bits     = '0;
    m_nbits    = 0;
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    cyc_i = 1'b1;
    stb_i = 1'b1;
    we_i  = 1'b1;
    dat_i = b;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (ack_o === 1'b1) begin
        model_byte(b);
        done = 1'b1;
      end
      step_cycle();
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: ack_o=%b, required 1 within 64 cycles", ack_o);
    end
  endtask

  task automatic end_frame(input string tag, input int exp_syms);
    int last = -1;
    int fell = -1;
    stb_i = 1'b0;
    cyc_i = 1'b0;
    we_i  = 1'b0;
    for (int p = (BPO - (m_bytes % BPO)) % BPO; p > 0; p--) model_byte(8'h00);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (stb_o && ack_i) last = k;
      if (cyc_o === 1'b0) begin
        fell = k;
        break;
      end
      step_cycle();
    end
    n_vec++;
    if (fell < 0) begin
      n_err++;
      $display("FAIL %s_cyc_timeout: cyc_o=%b, required 0 within 3000 cycles", tag, cyc_o);
    end
    n_vec++;
    if (n_xfer - frame_base != exp_syms) begin
      n_err++;
      $display("FAIL %s_sym_count: got %0d, required %0d", tag, n_xfer - frame_base, exp_syms);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_leftover: %0d symbols missing, required 0", tag, exp_q.size());
    end
    if (!rand_ack && fell >= 0) begin
      n_vec++;
      if (fell != last + 1) begin
        n_err++;
        $display("FAIL %s_cyc_fall: fell at %0d, required %0d", tag, fell, last + 1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; ack_i = 1'b0; dat_i = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({ack_o, stb_o, cyc_o, we_o} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b, required 0000", {ack_o, stb_o, cyc_o, we_o});
    end
    n_vec++;
    if (dat_o !== 6'h00) begin
      n_err++;
      $display("FAIL reset_dat: got %h, required 00", dat_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({stb_o, cyc_o} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_release: got %b, required 00", {stb_o, cyc_o});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_known_pattern();
    begin_frame();
    ack_i = 1'b1;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    end_frame("pat123", 48);
    n_vec++;
    if (first_sym !== FIRST_123) begin
      n_err++;
      $display("FAIL pat123_first: got %h, required %h", first_sym, FIRST_123);
    end
  endtask

  task automatic test_single_zero();
    begin_frame();
    ack_i = 1'b1;
    send_byte(8'h00);
    end_frame("zero1", 48);
    n_vec++;
    if (first_sym !== FIRST_00) begin
      n_err++;
      $display("FAIL zero1_first: got %h, required %h", first_sym, FIRST_00);
    end
  endtask

  task automatic test_full_symbol();
    begin_frame();
    ack_i = 1'b1;
    for (int i = 0; i < BPO; i++) send_byte(8'($urandom));
    end_frame("full36", 48);
    begin_frame();
    send_byte(8'h00);
    end_frame("reload", 48);
    n_vec++;
    if (first_sym !== FIRST_00) begin
      n_err++;
      $display("FAIL reload_first: got %h, required %h", first_sym, FIRST_00);
    end
  endtask

  task automatic test_backpressure();
    begin_frame();
    ack_i = 1'b0;
    send_byte(8'hA5);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = 8'h3C;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_vec++;
      if ({stb_o, ack_o, dat_o} !== {1'b1, 1'b0, exp_q[0]}) begin
        n_err++;
        $display("FAIL hold_%0d: stb/ack/dat %b/%b/%h, required 1/0/%h", k, stb_o, ack_o, dat_o, exp_q[0]);
      end
      @(posedge clk);
      #1;
    end
    ack_i = 1'b1;
    send_byte(8'h3C);
    send_byte(8'h0F);
    send_byte(8'hF0);
    end_frame("bp", 48);
  endtask

  task automatic test_idle_no_frame();
    ack_i = 1'b1;
    cyc_i = 1'b1; stb_i = 1'b0; we_i = 1'b1; dat_i = 8'h55;
    for (int k = 0; k < 10; k++) begin
      if (k == 5) begin
        stb_i = 1'b1;
        we_i  = 1'b0;
      end
      @(negedge clk);
      n_vec++;
      if ({ack_o, cyc_o, stb_o} !== 3'b000) begin
        n_err++;
        $display("FAIL idle_%0d: ack/cyc/stb %b, required 000", k, {ack_o, cyc_o, stb_o});
      end
      @(posedge clk);
      #1;
    end
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    begin_frame();
    ack_i = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    stb_i = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    cyc_i = 1'b0;
    we_i  = 1'b0;
    begin_frame();
    @(negedge clk);
    n_vec++;
    if ({ack_o, stb_o, cyc_o, we_o, dat_o} !== 10'd0) begin
      n_err++;
      $display("FAIL midrst_outputs: got %b, required all 0", {ack_o, stb_o, cyc_o, we_o, dat_o});
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      n_vec++;
      if ({cyc_o, stb_o} !== 2'b00) begin
        n_err++;
        $display("FAIL midrst_nopad_%0d: cyc/stb %b, required 00", k, {cyc_o, stb_o});
      end
    end
    @(posedge clk);
    #1;
    send_byte(8'h00);
    end_frame("postrst", 48);
    n_vec++;
    if (first_sym !== FIRST_00) begin
      n_err++;
      $display("FAIL postrst_first: got %h, required %h", first_sym, FIRST_00);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    rand_ack = 1'b1;
    for (int f = 0; f < 4; f++) begin
      begin_frame();
      n = $urandom_range(1, 80);
      for (int i = 0; i < n; i++) send_byte(8'($urandom));
      end_frame("rand", ((n + BPO - 1) / BPO) * 48);
    end
    rand_ack = 1'b0;
    ack_i    = 1'b1;
  endtask

  initial begin
    test_reset();
    test_known_pattern();
    test_single_zero();
    test_full_symbol();
    test_backpressure();
    test_idle_no_frame();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

endmodule
